// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: byte/state types, S-box and Rcon tables, round helpers.
// The decryptor imports this package and adds its inverse tables alongside.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [7:0] byte_t;
    // Element 0 occupies bits [127:120]; byte i sits at row i%4, column i/4.
    typedef byte_t [0:15] state_t;

    typedef enum logic {IDLE, RUN} fsm_t;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed directly by the round number 1..10; unused slots are padding.
    localparam byte_t RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic byte_t xtime(byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic state_t sub_bytes(state_t s);
        state_t r;
        for (int i = 0; i < 16; i++) r[i] = SBOX[s[i]];
        return r;
    endfunction

    function automatic state_t shift_rows(state_t s);
        state_t r;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[row + 4*c] = s[row + 4*((c + row) % 4)];
        return r;
    endfunction

    function automatic state_t mix_columns(state_t s);
        state_t r;
        byte_t  a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[4*c];
            a1 = s[4*c + 1];
            a2 = s[4*c + 2];
            a3 = s[4*c + 3];
            r[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    // One AES-128 key-schedule step: four new words from the previous round key.
    function automatic logic [127:0] expand_key(logic [127:0] rk, byte_t rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word(rot_word(rk[31:0])) ^ {rc, 24'h0};
        w0 = rk[127:96] ^ t;
        w1 = rk[95:64]  ^ w0;
        w2 = rk[63:32]  ^ w1;
        w3 = rk[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round; MixColumns is bypassed for the final round.
module aes_round
    import aes_pkg::*;
(
    input  state_t state,
    input  state_t round_key,
    input  logic   last,
    output state_t next_state
);

    state_t shifted;

    assign shifted    = shift_rows(sub_bytes(state));
    assign next_state = (last ? shifted : mix_columns(shifted)) ^ round_key;

endmodule

// File: rtl/aes_enc.sv
// Iterative AES-128 encryptor: one round per clock, key schedule expanded alongside.
// Accepts a block only while idle; pulses res_valid_out for one cycle with the ciphertext.
module aes_enc
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         data_valid_in,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic         busy_out,
    output logic         res_valid_out,
    output logic [127:0] res_enc_out
);

    fsm_t         fsm, fsm_nxt;
    state_t       st, round_out;
    logic [127:0] rk, rk_nxt;
    logic [3:0]   rnd;
    logic         last;

    assign last     = (rnd == 4'(NR));
    assign rk_nxt   = expand_key(rk, RCON[rnd]);
    assign busy_out = (fsm == RUN);

    aes_round u_round (
        .state      (st),
        .round_key  (rk_nxt),
        .last       (last),
        .next_state (round_out)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) fsm <= IDLE;
        else         fsm <= fsm_nxt;
    end

    // NOTE: combinational blocks assign every output a default first so no path can infer a latch.
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (data_valid_in) fsm_nxt = RUN;
            RUN:     if (last)          fsm_nxt = IDLE;
            default:                    fsm_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st            <= '0;
            rk            <= '0;
            rnd           <= '0;
            res_valid_out <= 1'b0;
            res_enc_out   <= '0;
        end else begin
            res_valid_out <= 1'b0;
            if (fsm == IDLE) begin
                // Inputs are only looked at here, so they may be X on any other cycle.
                if (data_valid_in) begin
                    st  <= data_in ^ key_in;
                    rk  <= key_in;
                    rnd <= 4'd1;
                end
            end else begin
                st <= round_out;
                rk <= rk_nxt;
                if (last) begin
                    res_enc_out   <= round_out;
                    res_valid_out <= 1'b1;
                    rnd           <= '0;
                end else begin
                    rnd <= rnd + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_enc.sv
// Scoreboard bench for aes_enc: known-answer vectors, busy drop, reset abort and random
// blocks checked against a byte-level AES model (with its inverse for round-trip).
module tb_aes_enc;

    logic         clk = 1'b0;
    logic         resetn;
    logic         data_valid_in;
    logic [127:0] data_in, key_in;
    logic         busy_out, res_valid_out;
    logic [127:0] res_enc_out;

    aes_enc dut (
        .clk           (clk),
        .resetn        (resetn),
        .data_valid_in (data_valid_in),
        .data_in       (data_in),
        .key_in        (key_in),
        .busy_out      (busy_out),
        .res_valid_out (res_valid_out),
        .res_enc_out   (res_enc_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] exp;
        int           acc;
    } exp_t;
    exp_t sb[$];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    // ---------------- reference model: built from GF(2^8) arithmetic ----------------
    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [8:0] aa;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            aa = {a, 1'b0};
            if (aa[8]) aa ^= 9'h11b;
            a = aa[7:0];
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] b, int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);
    endtask

    function automatic void expand(input logic [127:0] key, output logic [7:0] ek [176]);
        logic [7:0] t [4];
        logic [7:0] t0;
        logic [7:0] rc = 8'h01;
        for (int i = 0; i < 16; i++) ek[i] = key[127 - 8*i -: 8];
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) t[j] = ek[i - 4 + j];
            if (i % 16 == 0) begin
                t0   = t[0];
                t[0] = sbox_t[t[1]] ^ rc;
                t[1] = sbox_t[t[2]];
                t[2] = sbox_t[t[3]];
                t[3] = sbox_t[t0];
                rc   = gf_mul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) ek[i + j] = ek[i - 16 + j] ^ t[j];
        end
    endfunction

    // Column mix with a circulant matrix whose first row is cf (bytes MSB-first).
    function automatic void mix(inout logic [7:0] s [16], input logic [31:0] cf);
        logic [7:0] o [16];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                o[r + 4*c] = 8'h00;
                for (int k = 0; k < 4; k++)
                    o[r + 4*c] ^= gf_mul(cf[31 - 8*((k - r + 4) % 4) -: 8], s[k + 4*c]);
            end
        s = o;
    endfunction

    function automatic logic [127:0] model_enc(logic [127:0] pt, logic [127:0] key);
        logic [7:0]   ek [176];
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [127:0] out;
        expand(key, ek);
        for (int i = 0; i < 16; i++) st[i] = pt[127 - 8*i -: 8] ^ ek[i];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    tmp[r + 4*c] = sbox_t[st[r + 4*((c + r) % 4)]];
            if (rd < 10) mix(tmp, 32'h02030101);
            for (int i = 0; i < 16; i++) st[i] = tmp[i] ^ ek[16*rd + i];
        end
        for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = st[i];
        return out;
    endfunction

    function automatic logic [127:0] model_dec(logic [127:0] ct, logic [127:0] key);
        logic [7:0]   ek [176];
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [127:0] out;
        expand(key, ek);
        for (int i = 0; i < 16; i++) st[i] = ct[127 - 8*i -: 8] ^ ek[160 + i];
        for (int rd = 9; rd >= 0; rd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    tmp[r + 4*((c + r) % 4)] = st[r + 4*c];
            for (int i = 0; i < 16; i++) st[i] = isbox_t[tmp[i]] ^ ek[16*rd + i];
            if (rd > 0) mix(st, 32'h0e0b0d09);
        end
        for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = st[i];
        return out;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic prev_valid = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_valid) check("pulse_width", 128'(res_valid_out), 128'd0);
            if (res_valid_out) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 128'(res_valid_out), 128'd0);
                end else begin
                    e = sb.pop_front();
                    check("ciphertext", res_enc_out, e.exp);
                    check("latency", 128'(cyc - e.acc), 128'd10);
                    check("round_trip", model_dec(res_enc_out, e.key), e.pt);
                end
            end
            prev_valid = res_valid_out;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Present a block for the next rising edge, then release the inputs to X.
    task automatic send(input logic [127:0] pt, input logic [127:0] key,
                        input logic [127:0] exp, input bit expect_result);
        exp_t e;
        data_valid_in = 1'b1;
        data_in       = pt;
        key_in        = key;
        if (expect_result) begin
            e.pt  = pt;
            e.key = key;
            e.exp = exp;
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #2;
        data_valid_in = 1'b0;
        data_in       = 'x;
        key_in        = 'x;
    endtask

    task automatic wait_done();
        int i = 0;
        while ((sb.size() != 0 || busy_out) && i < 40) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (sb.size() != 0 || busy_out) begin
            check("timeout", 128'(sb.size()), 128'd0);
            sb.delete();
        end
    endtask

    initial begin
        logic [127:0] pt, key;
        int i;
        build_tables();
        resetn        = 1'b0;
        data_valid_in = 1'b0;
        data_in       = '0;
        key_in        = '0;
        #12;
        check("reset_busy",  128'(busy_out), 128'd0);
        check("reset_valid", 128'(res_valid_out), 128'd0);
        check("reset_res",   res_enc_out, 128'd0);
        @(negedge clk);
        resetn = 1'b1;
        idle(2);

        // FIPS-197 C.1, then App. B with X driven on every non-accept cycle.
        send(C1_PT, C1_KEY, C1_CT, 1'b1);
        wait_done();
        idle(1);
        send(B_PT, B_KEY, B_CT, 1'b1);
        check("busy_after_accept", 128'(busy_out), 128'd1);
        wait_done();
        idle(1);

        // All-zero block, then C.1 presented in the very cycle the result pulses.
        send('0, '0, Z_CT, 1'b1);
        i = 0;
        while (!res_valid_out && i < 20) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("b2b_valid_seen", 128'(res_valid_out), 128'd1);
        check("b2b_idle", 128'(busy_out), 128'd0);
        send(C1_PT, C1_KEY, C1_CT, 1'b1);
        wait_done();
        idle(1);

        // Requests arriving while busy are dropped.
        send(C1_PT, C1_KEY, C1_CT, 1'b1);
        idle(2);
        check("busy_drop_n3", 128'(busy_out), 128'd1);
        send(B_PT, B_KEY, B_CT, 1'b0);
        idle(5);
        check("busy_drop_n9", 128'(busy_out), 128'd1);
        send(B_PT, B_KEY, B_CT, 1'b0);
        check("busy_after_drop", 128'(busy_out), 128'd1);
        wait_done();
        idle(30);

        // Reset in flight aborts the block; the next one runs normally.
        send(C1_PT, C1_KEY, C1_CT, 1'b0);
        idle(4);
        @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("abort_busy",  128'(busy_out), 128'd0);
        check("abort_valid", 128'(res_valid_out), 128'd0);
        check("abort_res",   res_enc_out, 128'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        idle(1);
        send(B_PT, B_KEY, B_CT, 1'b1);
        wait_done();
        idle(15);

        for (int n = 0; n < 100; n++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            send(pt, key, model_enc(pt, key), 1'b1);
            wait_done();
            idle($urandom_range(0, 2));
        end

        idle(3);
        check("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
